// File: rtl/vu_cmd_issue_if.sv
// Request and queue handshake bundle between the scalar coprocessor port,
// the command issuer and the vector unit's cmdq/immq/imm2q.
interface vu_cmd_issue_if #(
  parameter int unsigned OP_SZ  = 8,
  parameter int unsigned REG_SZ = 6,
  parameter int unsigned CMD_SZ = 20,
  parameter int unsigned IMM_SZ = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [OP_SZ-1:0]  req_op;
  logic [REG_SZ-1:0] req_vd;
  logic [REG_SZ-1:0] req_vt;
  logic [IMM_SZ-1:0] req_imm;
  logic [IMM_SZ-1:0] req_imm2;

  logic              cmdq_valid;
  logic              cmdq_ready;
  logic [CMD_SZ-1:0] cmdq_bits;
  logic              immq_valid;
  logic              immq_ready;
  logic [IMM_SZ-1:0] immq_bits;
  logic              imm2q_valid;
  logic              imm2q_ready;
  logic [IMM_SZ-1:0] imm2q_bits;

  // master: the issuer (accepts requests, drives the queues)
  modport master (
    input  req_valid, req_op, req_vd, req_vt, req_imm, req_imm2,
    output req_ready,
    output cmdq_valid, cmdq_bits, immq_valid, immq_bits, imm2q_valid, imm2q_bits,
    input  cmdq_ready, immq_ready, imm2q_ready
  );

  // slave: the requester and the queue sinks
  modport slave (
    output req_valid, req_op, req_vd, req_vt, req_imm, req_imm2,
    input  req_ready,
    input  cmdq_valid, cmdq_bits, immq_valid, immq_bits, imm2q_valid, imm2q_bits,
    output cmdq_ready, immq_ready, imm2q_ready
  );
endinterface

// File: rtl/vu_cmd_issue.sv
// Vector-unit command issuer: latches one request, pushes cmd/imm/imm2 words
// onto independent queues, and stalls new requests behind .cv fences.
module vu_cmd_issue #(
  parameter int unsigned OP_SZ  = 8,
  parameter int unsigned REG_SZ = 6,
  parameter int unsigned CMD_SZ = 20,
  parameter int unsigned IMM_SZ = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  vu_cmd_issue_if.master    q,
  input  logic              fence_done,
  output logic              busy,
  output logic [15:0]       issue_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] FENCE = 2'd2;

  logic [1:0]        state;
  logic              pend_cmd, pend_imm, pend_imm2;
  logic              fence_cv;
  logic [CMD_SZ-1:0] cmd_bits;
  logic [IMM_SZ-1:0] imm_bits, imm2_bits;
  logic [15:0]       count;

  logic need_imm, need_imm2, is_cv_fence;
  logic pend_cmd_nxt, pend_imm_nxt, pend_imm2_nxt;
  logic all_done;

  always_comb begin
    need_imm    = 1'b0;
    need_imm2   = 1'b0;
    is_cv_fence = 1'b0;
    case (q.req_op[7:6])
      2'b00: begin
        need_imm    = (q.req_op[5:4] != 2'b11);
        is_cv_fence = (q.req_op[5:4] == 2'b11) && q.req_op[1];
      end
      2'b01:   need_imm = q.req_op[0];
      2'b10:   need_imm = 1'b1;
      default: begin
        need_imm  = 1'b1;
        need_imm2 = 1'b1;
      end
    endcase
  end

  // Valids are the pend flops themselves, so a fire is pend & ready.
  always_comb begin
    pend_cmd_nxt  = pend_cmd  & ~q.cmdq_ready;
    pend_imm_nxt  = pend_imm  & ~q.immq_ready;
    pend_imm2_nxt = pend_imm2 & ~q.imm2q_ready;
    all_done      = ~(pend_cmd_nxt | pend_imm_nxt | pend_imm2_nxt);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pend_cmd  <= 1'b0;
      pend_imm  <= 1'b0;
      pend_imm2 <= 1'b0;
      fence_cv  <= 1'b0;
      cmd_bits  <= '0;
      imm_bits  <= '0;
      imm2_bits <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (q.req_valid) begin
            cmd_bits  <= {q.req_op, q.req_vd, q.req_vt};
            imm_bits  <= q.req_imm;
            imm2_bits <= q.req_imm2;
            pend_cmd  <= 1'b1;
            pend_imm  <= need_imm;
            pend_imm2 <= need_imm2;
            fence_cv  <= is_cv_fence;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          pend_cmd  <= pend_cmd_nxt;
          pend_imm  <= pend_imm_nxt;
          pend_imm2 <= pend_imm2_nxt;
          if (all_done) begin
            count <= count + 16'd1;
            state <= fence_cv ? FENCE : IDLE;
          end
        end
        FENCE: begin
          if (fence_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign q.req_ready   = (state == IDLE);
  assign q.cmdq_valid  = pend_cmd;
  assign q.immq_valid  = pend_imm;
  assign q.imm2q_valid = pend_imm2;
  assign q.cmdq_bits   = cmd_bits;
  assign q.immq_bits   = imm_bits;
  assign q.imm2q_bits  = imm2_bits;
  assign busy          = (state != IDLE);
  assign issue_count   = count;

endmodule

// File: doc/vu_cmd_issue.md
# vu_cmd_issue

Command issuer for the vector unit's command interface. It is the transmit end of the command queues that the vector unit decodes. It accepts one high-level request at a time, packs the command word, and decides from the opcode which immediate words accompany it. It pushes the command, immediate and second-immediate words onto their three queues with independent valid/ready handshakes. It also holds off further requests while a fence that needs completion is outstanding. It sits between the scalar core's coprocessor port and the vector unit's cmdq/immq/imm2q.

## Interface
Parameters:
- OP_SZ, 8, opcode field width
- REG_SZ, 6, register specifier width (vd, vt)
- CMD_SZ, 20, command word width; must equal OP_SZ+2*REG_SZ
- IMM_SZ, 64, immediate word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  OP_SZ  opcode
- req_vd  in  REG_SZ  destination register
- req_vt  in  REG_SZ  source register
- req_imm  in  IMM_SZ  immediate (address, vlen, config or scalar)
- req_imm2  in  IMM_SZ  second immediate (stride)
- cmdq_valid / cmdq_ready  out / in  1  command queue handshake
- cmdq_bits  out  CMD_SZ  {op, vd, vt}
- immq_valid / immq_ready  out / in  1  immediate queue handshake
- immq_bits  out  IMM_SZ  latched req_imm
- imm2q_valid / imm2q_ready  out / in  1  second-immediate queue handshake
- imm2q_bits  out  IMM_SZ  latched req_imm2
- fence_done  in  1  one-cycle pulse: vector unit finished all work prior to a .cv fence
- busy  out  1  state != IDLE
- issue_count  out  16  commands fully issued, wraps 0xFFFF->0x0000

## Operation
Decode of op[7:6] gives the word set for each request:
- 00 control. op[5:4]: 00 vvcfgivl, 01 vsetvl, 10 vf (cmd+imm). 11 fence (cmd only); op[1:0]: 00 l.v, 01 g.v, 10 l.cv, 11 g.cv.
- 01 move: op[0]=1 is a scalar-sourced move (vmsv/vfmsv/vmst class) and sends cmd+imm. op[0]=0 sends cmd only.
- 10 unit-stride or indexed memory: cmd+imm (base address).
- 11 strided memory: cmd+imm+imm2.

State machine:
- IDLE: req_ready=1. On fire, latch op/vd/vt/imm/imm2. Set pend_cmd=1, pend_imm and pend_imm2 per decode. Go to ISSUE.
- ISSUE: cmdq_valid=pend_cmd, immq_valid=pend_imm, imm2q_valid=pend_imm2, all driven concurrently. Each pend bit clears on its own valid&ready. When the last set pend bit clears in a cycle, issue_count increments. Next state is FENCE if the op is a .cv fence, otherwise IDLE.
- FENCE: all valids 0, req_ready=0. On fence_done go to IDLE. fence_done outside FENCE is ignored.

Queue rules:
- Once asserted, a valid stays high and its bits stay stable until it fires.
- The three queues need no mutual ordering.

Reset (async assert, sync deassert assumed at the system level):
- state=IDLE, pend bits=0, all *_valid=0, issue_count=0, bits registers=0, busy=0, req_ready=1 after reset.
- Reset mid-ISSUE drops the partially issued request. Words already accepted by a queue are not recalled.

## Timing
- All outputs are registered or decoded from state and pend flops only. There is no combinational path from any *_ready or req_* input to any output.
- Request accepted on edge N: valids are high in cycle N+1.
- With all readys held high, the request completes at edge N+1 and req_ready returns in cycle N+2. Throughput is 1 request per 2 cycles.
- A queue stalled k cycles extends ISSUE by k cycles. The other queues fire independently during the stall.
- .cv fence: FENCE is entered the cycle after the cmd fires. IDLE follows the cycle after a fence_done pulse. If fence_done arrives in the same cycle the cmd fires, it is ignored, because the pulse must land in FENCE.
- issue_count updates on the same edge as the final fire.

## Test plan
- vsetvl (op=0x10, imm=32), readys high -> cmdq_bits={0x10,vd,vt} and immq_bits=32 both valid in cycle N+1; imm2q_valid=0; issue_count=1; req_ready high again at N+2.
- Strided load (op=0xC0, imm=0x1000, imm2=8), immq_ready low 3 cycles -> cmd and imm2 fire at N+1; imm valid held 0x1000 through N+4 and fires; issue_count increments at N+4 only.
- vmvv (op=0x40) -> cmd only; immq_valid and imm2q_valid never assert.
- g.cv fence (op=0x33) -> cmd fires; busy stays 1 and req_ready 0 until fence_done; IDLE the next cycle. An l.v fence (0x30) returns to IDLE with no wait.
- reset_n low mid-ISSUE with cmdq_ready low -> all valids 0 immediately, asynchronously; issue_count=0; req_ready=1 after release.
- 65536 back-to-back vf requests -> issue_count wraps to 0x0000; no request lost, checked against a scoreboard of queue outputs.
